bram_dp_param: RTL and testbench
================================

Name: bram_dp_param

Overview:
- Parametrised true-dual-port block RAM with a single clock. It is the successor to the fixed 64x1024 dual-port BRAM wrapper.
- Adds generic width and depth, per-byte write enables, and a selectable read latency with an optional output register.
- Adds a per-port read-valid pipeline, a configurable read-during-write mode, and same-address write-collision arbitration with a sticky flag.
- Sits between Chisel-generated datapaths and on-chip storage. The array is written for inference: no vendor IP.

Parameters:
- DATA_W, 64, data width in bits; must be a multiple of 8.
- ADDR_W, 10, address width; depth = 2**ADDR_W.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register).
- WR_MODE, 0, read-during-write behaviour on the same port: 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE.

Ports:
- clk  in  1  single clock for both ports.
- resetn  in  1  asynchronous, active-low reset.
- ena  in  1  port A enable.
- wea  in  DATA_W/8  port A byte write enables.
- addra  in  ADDR_W  port A address.
- dina  in  DATA_W  port A write data.
- douta  out  DATA_W  port A read data.
- valida  out  1  douta holds data from a read issued RD_LAT cycles earlier.
- enb, web, addrb, dinb, doutb, validb  same as the port A signals, for port B.
- collision  out  1  sticky flag: a same-address write collision has occurred.
- clr_collision  in  1  synchronous clear of the collision flag.

Behaviour:
- Reset (resetn low, asynchronous):
  - douta, doutb, valida, validb, collision and all pipeline stages go to 0.
  - Memory contents are not reset. Reads of unwritten locations return X in simulation.
- Access classes on each port:
  - Read: en=1 and we=0.
  - Write: en=1 and we!=0; only the bytes whose we bit is set are written.
  - Idle: en=0; no access, and the output does not change.
- Latency:
  - RD_LAT=1: dout is registered at the array. The value from an access issued in cycle N is valid at cycle N+1.
  - RD_LAT=2: an extra output register moves this to N+2.
  - In both cases valid is en delayed by RD_LAT, asserted for reads and for writes in READ_FIRST or WRITE_FIRST mode.
- Same-port read-during-write:
  - READ_FIRST: dout shows the old word.
  - WRITE_FIRST: dout shows the merged new word (unwritten bytes keep old data).
  - NO_CHANGE: dout holds its previous value and valid stays 0 for that access.
- Cross-port, same address, same cycle:
  - A writes and B reads (or B writes and A reads): the reader gets the old word. Documented read-first across ports; no forwarding.
  - Both write: byte lanes enabled on A take A's data. Byte lanes enabled only on B take B's data. Port A has priority.
  - If the byte-enable masks overlap, collision is set at the next edge.
- collision flag:
  - Stays set until clr_collision=1.
  - A new collision in the same cycle as a clear wins: the flag stays 1.
- Pipeline stall: none. Pipelines advance every cycle and the output register loads only when its stage-valid bit is 1. Idle cycles therefore hold dout at its last value, and valid drops.
- Reset mid-operation: in-flight reads are discarded (valid=0). Writes already committed to the array persist.
- Address wrap: none needed; all ADDR_W values are legal.
- Simulation checks:
  - Elaboration check rejects DATA_W%8!=0, RD_LAT not in {1,2}, and WR_MODE>2.
  - A simulation-only assertion flags X on en or we.

Decomposition:
- Shared package bram_pkg: WR_MODE encodings (WM_READ_FIRST=0, WM_WRITE_FIRST=1, WM_NO_CHANGE=2) and a byte-merge function (old, new, mask).
- Sub-module bram_rd_pipe: one per port. It carries the valid bit and data through the RD_LAT stages and applies the NO_CHANGE hold.
- The array and collision logic stay in the top module.
- Expected size is about 200 RTL lines.

Test Plan:
- Reset, then A writes 0x1122334455667788 to addr 5 with wea=0xFF; B reads addr 5 two cycles later → doutb=0x1122334455667788 with validb=1, exactly RD_LAT cycles after the read.
- Byte merge, WR_MODE=1: A writes 0xAA..AA to addr 7 with wea=0x0F over an existing 0x0 word → same-cycle douta=0x00000000AAAAAAAA.
- READ_FIRST, cross-port: addr 3 holds 0x1; in the same cycle A writes 0x2 to addr 3 and B reads addr 3 → doutb=0x1. The next read of addr 3 gives 0x2.
- Dual-write collision: A writes 0x…FF with wea=0xFF and B writes 0x…EE with wea=0x01, both to addr 9 → stored word has lane 0 = 0xFF, collision=1 at the next edge. clr_collision=1 then returns it to 0.
- RD_LAT=2, NO_CHANGE: back-to-back reads of addr 1 and addr 2 give data at N+2 and N+3. A write in between leaves dout unchanged with valid=0.
- Assert resetn low while a read is in flight → valid and dout go to 0 asynchronously. After release, a re-read returns the pre-reset written data.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared definitions for the parametrised dual-port block RAM: read-during-write
// mode encodings and the byte-lane merge used for write-first read data.
package bram_pkg;

  typedef enum logic [1:0] {
    WM_READ_FIRST  = 2'd0,
    WM_WRITE_FIRST = 2'd1,
    WM_NO_CHANGE   = 2'd2
  } wr_mode_e;

  // One byte lane of a masked merge: the new byte replaces the old one when its enable is set.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       mask);
    return mask ? new_b : old_b;
  endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Per-port read pipeline: carries the valid bit and read word through RD_LAT
// stages; each output register loads only when its stage holds a valid read.
module bram_rd_pipe
  import bram_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int RD_LAT  = 1,
  parameter int WR_MODE = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic              wr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              valid
);

  localparam bit HOLD_ON_WRITE = (WR_MODE == int'(WM_NO_CHANGE));

  logic              issue;
  logic              v1;
  logic [DATA_W-1:0] d1;

  // A NO_CHANGE write is treated like an idle cycle so the output keeps its value.
  assign issue = en && !(wr && HOLD_ON_WRITE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= issue;
      if (issue) d1 <= din;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_oreg
      logic              v2;
      logic [DATA_W-1:0] d2;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= v1;
          if (v1) d2 <= d1;
        end
      end

      assign dout  = d2;
      assign valid = v2;
    end else begin : g_direct
      assign dout  = d1;
      assign valid = v1;
    end
  endgenerate

endmodule

// File: rtl/bram_dp_param.sv
// Parametrised single-clock true-dual-port block RAM with byte write enables,
// selectable read latency, read-during-write mode and sticky collision flag.
module bram_dp_param
  import bram_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 10,
  parameter int RD_LAT  = 1,
  parameter int WR_MODE = 0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ena,
  input  logic [DATA_W/8-1:0] wea,
  input  logic [ADDR_W-1:0]   addra,
  input  logic [DATA_W-1:0]   dina,
  output logic [DATA_W-1:0]   douta,
  output logic                valida,
  input  logic                enb,
  input  logic [DATA_W/8-1:0] web,
  input  logic [ADDR_W-1:0]   addrb,
  input  logic [DATA_W-1:0]   dinb,
  output logic [DATA_W-1:0]   doutb,
  output logic                validb,
  output logic                collision,
  input  logic                clr_collision
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  generate
    if (DATA_W % 8 != 0) begin : g_bad_data_w
      $error("bram_dp_param: DATA_W must be a multiple of 8");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
      $error("bram_dp_param: RD_LAT must be 1 or 2");
    end
    if (WR_MODE < 0 || WR_MODE > 2) begin : g_bad_wr_mode
      $error("bram_dp_param: WR_MODE must be 0, 1 or 2");
    end
  endgenerate

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] rd_a, rd_b;
  logic [DATA_W-1:0] port_a, port_b;
  logic              wr_a, wr_b;
  logic              col_now;

  assign rd_a = mem[addra];
  assign rd_b = mem[addrb];
  assign wr_a = |wea;
  assign wr_b = |web;

  always_comb begin
    port_a = rd_a;
    port_b = rd_b;
    if (WR_MODE == int'(WM_WRITE_FIRST)) begin
      for (int unsigned i = 0; i < NB; i++) begin
        port_a[i*8 +: 8] = byte_merge(rd_a[i*8 +: 8], dina[i*8 +: 8], wea[i]);
        port_b[i*8 +: 8] = byte_merge(rd_b[i*8 +: 8], dinb[i*8 +: 8], web[i]);
      end
    end
  end

  // Port A's lane write is scheduled after port B's, so A wins on shared lanes.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NB; i++) begin
      if (enb && web[i]) mem[addrb][i*8 +: 8] <= dinb[i*8 +: 8];
      if (ena && wea[i]) mem[addra][i*8 +: 8] <= dina[i*8 +: 8];
    end
  end

  assign col_now = ena && enb && (addra == addrb) && (|(wea & web));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      collision <= 1'b0;
    end else if (col_now) begin
      collision <= 1'b1;
    end else if (clr_collision) begin
      collision <= 1'b0;
    end
  end

  bram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT),
    .WR_MODE(WR_MODE)
  ) u_pipe_a (
    .clk   (clk),
    .resetn(resetn),
    .en    (ena),
    .wr    (wr_a),
    .din   (port_a),
    .dout  (douta),
    .valid (valida)
  );

  bram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT),
    .WR_MODE(WR_MODE)
  ) u_pipe_b (
    .clk   (clk),
    .resetn(resetn),
    .en    (enb),
    .wr    (wr_b),
    .din   (port_b),
    .dout  (doutb),
    .valid (validb)
  );

  always_ff @(posedge clk) begin
    if (resetn) assert (!$isunknown({ena, enb, wea, web}));
  end

endmodule

// File: tb/tb_bram_dp_param.sv
// Bench for bram_dp_param: three configurations share one stimulus stream and
// one reference memory; per-port expected results flow through latency queues.
module tb_bram_dp_param;

  localparam int LAT  [3] = '{1, 1, 2};
  localparam int MODE [3] = '{0, 1, 2};

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        ena, enb, clr;
  logic [7:0]  wea, web;
  logic [9:0]  addra, addrb;
  logic [63:0] dina, dinb;

  logic [63:0] dout  [6];
  logic        valid [6];
  logic        coll  [3];

  int checks = 0;
  int errors = 0;

  logic [65:0] q [6][$];
  logic [63:0] held [6];
  bit          hk   [6];
  logic [63:0] mm [int];
  logic        coll_m;
  string       nm [6] = '{"d0a", "d0b", "d1a", "d1b", "d2a", "d2b"};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bram_dp_param #(
      .DATA_W (64),
      .ADDR_W (10),
      .RD_LAT (LAT[g]),
      .WR_MODE(MODE[g])
    ) u_dut (
      .clk          (clk),
      .resetn       (resetn),
      .ena          (ena),
      .wea          (wea),
      .addra        (addra),
      .dina         (dina),
      .douta        (dout[2*g]),
      .valida       (valid[2*g]),
      .enb          (enb),
      .web          (web),
      .addrb        (addrb),
      .dinb         (dinb),
      .doutb        (dout[2*g+1]),
      .validb       (valid[2*g+1]),
      .collision    (coll[g]),
      .clr_collision(clr)
    );
  end

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] merge64(input logic [63:0] old_w, input logic [63:0] new_w,
                                          input logic [7:0] m);
    logic [63:0] r;
    r = old_w;
    for (int i = 0; i < 8; i++) if (m[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] rd_m(input logic [9:0] a, output bit known);
    known = mm.exists(int'(a));
    return known ? mm[int'(a)] : 64'h0;
  endfunction

  // {dont_care, valid, data} that the port must show RD_LAT cycles later
  function automatic logic [65:0] exp_entry(input int k, input logic en, input logic [7:0] we,
                                            input logic [63:0] din, input logic [63:0] old_w,
                                            input bit known);
    if (!en) return '0;
    if (we == 8'h00) return {!known, 1'b1, old_w};
    if (MODE[k] == 2) return '0;
    if (MODE[k] == 1) return {!(known || we == 8'hFF), 1'b1, merge64(old_w, din, we)};
    return {!known, 1'b1, old_w};
  endfunction

  task automatic cyc();
    logic [63:0] oa, ob, cur;
    bit          ka, kb, kc;
    logic [65:0] e;
    @(posedge clk);
    oa = rd_m(addra, ka);
    ob = rd_m(addrb, kb);
    for (int k = 0; k < 3; k++) begin
      q[2*k].push_back(exp_entry(k, ena, wea, dina, oa, ka));
      q[2*k+1].push_back(exp_entry(k, enb, web, dinb, ob, kb));
    end
    if (enb && web != 8'h00) mm[int'(addrb)] = merge64(ob, dinb, web);
    if (ena && wea != 8'h00) begin
      cur = rd_m(addra, kc);
      mm[int'(addra)] = merge64(cur, dina, wea);
    end
    if (ena && enb && addra == addrb && (wea & web) != 8'h00) coll_m = 1'b1;
    else if (clr) coll_m = 1'b0;
    #1;
    for (int j = 0; j < 6; j++) begin
      if (q[j].size() >= LAT[j/2]) begin
        e = q[j].pop_front();
        if (e[64]) begin
          held[j] = e[63:0];
          hk[j]   = !e[65];
        end
        if (hk[j]) check(nm[j], {valid[j], dout[j]}, {e[64], held[j]});
        else       check(nm[j], {64'h0, valid[j]}, {64'h0, e[64]});
      end
    end
    for (int k = 0; k < 3; k++) check("coll", {64'h0, coll[k]}, {64'h0, coll_m});
  endtask

  task automatic reset_check();
    resetn = 1'b0;
    #1;
    for (int j = 0; j < 6; j++) check("rst_out", {valid[j], dout[j]}, 65'h0);
    for (int k = 0; k < 3; k++) check("rst_coll", {64'h0, coll[k]}, 65'h0);
    for (int j = 0; j < 6; j++) begin
      q[j].delete();
      held[j] = '0;
      hk[j]   = 1'b1;
      if (LAT[j/2] == 2) q[j].push_back('0);
    end
    coll_m = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic drv_a(input logic en, input logic [7:0] we, input int a, input logic [63:0] d);
    ena = en; wea = we; addra = a[9:0]; dina = d;
  endtask

  task automatic drv_b(input logic en, input logic [7:0] we, input int a, input logic [63:0] d);
    enb = en; web = we; addrb = a[9:0]; dinb = d;
  endtask

  task automatic idle();
    drv_a(1'b0, 8'h00, 0, 64'h0);
    drv_b(1'b0, 8'h00, 0, 64'h0);
  endtask

  function automatic logic [63:0] init_val(input int i);
    if (i == 3) return 64'h1;
    if (i == 7) return 64'h0;
    return {32'h5EED0000 | i, 32'h0BAD0000 | i};
  endfunction

  initial begin
    idle();
    clr = 1'b0;
    #2;
    reset_check();

    for (int i = 0; i < 16; i++) begin
      drv_a(1'b1, 8'hFF, i, init_val(i));
      cyc();
    end
    idle(); cyc();

    // Write on A, read on B two cycles later
    drv_a(1'b1, 8'hFF, 5, 64'h1122334455667788); cyc();
    idle(); cyc();
    drv_b(1'b1, 8'h00, 5, 64'h0); cyc();
    check("b_read_lat1", {valid[1], dout[1]}, {1'b1, 64'h1122334455667788});
    idle(); cyc();
    check("b_read_lat2", {valid[5], dout[5]}, {1'b1, 64'h1122334455667788});
    cyc();

    // Partial-lane write seen same cycle in WRITE_FIRST
    drv_a(1'b1, 8'h0F, 7, {8{8'hAA}}); cyc();
    check("wf_merge", {valid[2], dout[2]}, {1'b1, 64'h00000000AAAAAAAA});
    idle(); cyc();

    // Cross-port read during write returns the old word
    drv_a(1'b1, 8'hFF, 3, 64'h2);
    drv_b(1'b1, 8'h00, 3, 64'h0); cyc();
    check("xport_old", {valid[1], dout[1]}, {1'b1, 64'h1});
    drv_a(1'b0, 8'h00, 0, 64'h0); cyc();
    check("xport_new", {valid[1], dout[1]}, {1'b1, 64'h2});
    idle(); cyc(); cyc();

    // Dual write with overlapping lanes, then clear
    drv_a(1'b1, 8'hFF, 9, 64'h00000000000000FF);
    drv_b(1'b1, 8'h01, 9, 64'h00000000000000EE); cyc();
    check("coll_set", {64'h0, coll[0]}, 65'h1);
    drv_a(1'b0, 8'h00, 0, 64'h0);
    drv_b(1'b1, 8'h00, 9, 64'h0); cyc();
    check("dual_lane0", {57'h0, dout[1][7:0]}, 65'hFF);
    idle(); clr = 1'b1; cyc();
    check("coll_clr", {64'h0, coll[0]}, 65'h0);
    drv_a(1'b1, 8'h03, 9, 64'h1);
    drv_b(1'b1, 8'h02, 9, 64'h2); cyc();
    check("coll_beats_clr", {64'h0, coll[1]}, 65'h1);
    idle(); cyc();
    clr = 1'b0;

    // Disjoint lanes on the same address: no collision, lanes combine
    drv_a(1'b1, 8'hF0, 10, {8{8'h11}});
    drv_b(1'b1, 8'h0F, 10, {8{8'h22}}); cyc();
    drv_a(1'b0, 8'h00, 0, 64'h0);
    drv_b(1'b1, 8'h00, 10, 64'h0); cyc();
    check("disjoint_lanes", {valid[1], dout[1]}, {1'b1, 64'h1111111122222222});
    idle(); cyc(); cyc();

    // Back-to-back reads with a write in between on the RD_LAT=2 NO_CHANGE port
    drv_a(1'b1, 8'h00, 1, 64'h0); cyc();
    drv_a(1'b1, 8'h00, 2, 64'h0); cyc();
    check("nc_rd1", {valid[4], dout[4]}, {1'b1, init_val(1)});
    drv_a(1'b1, 8'hFF, 4, 64'hDEAD); cyc();
    check("nc_rd2", {valid[4], dout[4]}, {1'b1, init_val(2)});
    idle(); cyc();
    check("nc_hold", {valid[4], dout[4]}, {1'b0, init_val(2)});
    cyc();

    // Reset with a read in flight; memory contents survive
    drv_a(1'b1, 8'h00, 5, 64'h0); cyc();
    idle();
    reset_check();
    drv_a(1'b1, 8'h00, 5, 64'h0); cyc();
    check("post_rst_lat1", {valid[0], dout[0]}, {1'b1, 64'h1122334455667788});
    idle(); cyc();
    check("post_rst_lat2", {valid[4], dout[4]}, {1'b1, 64'h1122334455667788});

    // Random traffic over the initialised address range
    for (int n = 0; n < 80; n++) begin
      int a;
      a = int'($urandom_range(0, 15));
      drv_a(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
            a, {$urandom, $urandom});
      drv_b(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
            ($urandom_range(0, 1) == 0) ? a : int'($urandom_range(0, 15)), {$urandom, $urandom});
      clr = ($urandom_range(0, 7) == 0);
      cyc();
    end
    idle(); clr = 1'b0;
    cyc(); cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
